// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch / data) arbiter onto a single shared memory bus.
// Data wins ties unless fetch has been starved; an ack timeout raises a one-cycle bus error.
module mem_bus_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int STARVE_MAX  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_cplt,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_cplt,
    output logic        m_req,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic [31:0] m_rdata,
    input  logic        m_ack,
    output logic        bus_err,
    output logic [7:0]  err_num
);
    // state  | meaning
    // IDLE   | no transfer owned; arbitrate unless a completion is being reported
    // GNT_IF | fetch owns the bus, waiting for m_ack
    // GNT_D  | data owns the bus, waiting for m_ack
    // ERR    | one-cycle timeout report to the owner
    typedef enum logic [1:0] {IDLE, GNT_IF, GNT_D, ERR} state_t;

    localparam int WW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam int SW = ($clog2(STARVE_MAX + 1) < 2) ? 2 : $clog2(STARVE_MAX + 1);
    localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT_CYC - 1);
    localparam logic [SW-1:0] STARVE_SAT = SW'(STARVE_MAX);

    state_t        state, state_nxt;
    logic          grant_if, grant_d, done, timeout;
    logic [WW-1:0] wait_cnt;
    logic [SW-1:0] starve_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                // hold off one cycle while a completion pulse is visible
                if (!(if_cplt || d_cplt)) begin
                    if (if_req && (!d_req || starve_cnt == STARVE_SAT)) begin
                        grant_if  = 1'b1;
                        state_nxt = GNT_IF;
                    end else if (d_req) begin
                        grant_d   = 1'b1;
                        state_nxt = GNT_D;
                    end
                end
            end
            GNT_IF, GNT_D: begin
                if (m_ack && m_req) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ERR;
                end
            end
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_cplt    <= 1'b0;
            d_cplt     <= 1'b0;
            bus_err    <= 1'b0;
            err_num    <= '0;
            wait_cnt   <= '0;
            starve_cnt <= '0;
        end else begin
            if_cplt <= 1'b0;
            d_cplt  <= 1'b0;
            bus_err <= 1'b0;
            err_num <= '0;
            if (grant_if) begin
                m_req      <= 1'b1;
                m_we       <= 1'b0;
                m_addr     <= if_addr;
                m_wdata    <= '0;
                wait_cnt   <= '0;
                starve_cnt <= '0;
            end else if (grant_d) begin
                m_req    <= 1'b1;
                m_we     <= d_we;
                m_addr   <= d_addr;
                m_wdata  <= d_wdata;
                wait_cnt <= '0;
                if (if_req && starve_cnt != STARVE_SAT)
                    starve_cnt <= starve_cnt + SW'(1);
            end else if (done) begin
                m_req <= 1'b0;
                if (state == GNT_IF) begin
                    if_rdata <= m_rdata;
                    if_cplt  <= 1'b1;
                end else begin
                    if (!m_we) d_rdata <= m_rdata;
                    d_cplt <= 1'b1;
                end
            end else if (timeout) begin
                m_req   <= 1'b0;
                bus_err <= 1'b1;
                err_num <= 8'd4;
                if (state == GNT_IF) begin
                    if_rdata <= '0;
                    if_cplt  <= 1'b1;
                end else begin
                    d_rdata <= '0;
                    d_cplt  <= 1'b1;
                end
            end else if (state == GNT_IF || state == GNT_D) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
        end
    end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255: maximum wait cycles for m_ack before a bus error.
REQ-002 Parameter STARVE_MAX, default 3: consecutive lost arbitrations after which fetch wins.
REQ-003 clk  input  1  single clock; all logic on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 if_req  input  1  fetch request, level, held until if_cplt.
REQ-006 if_addr  input  32  fetch address (pc).
REQ-007 if_rdata  output  32  fetched instruction.
REQ-008 if_cplt  output  1  one-cycle fetch completion pulse.
REQ-009 d_req  input  1  data request, level, held until d_cplt.
REQ-010 d_we  input  1  1=store, 0=load.
REQ-011 d_addr  input  32  data address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_rdata  output  32  load data.
REQ-014 d_cplt  output  1  one-cycle data completion pulse.
REQ-015 m_req  output  1  shared memory bus request.
REQ-016 m_we  output  1  shared bus write enable.
REQ-017 m_addr  output  32  shared bus address.
REQ-018 m_wdata  output  32  shared bus write data.
REQ-019 m_rdata  input  32  shared bus read data, valid with m_ack.
REQ-020 m_ack  input  1  one-cycle transfer acknowledge.
REQ-021 bus_err  output  1  one-cycle timeout pulse.
REQ-022 err_num  output  8  interrupt number; 8'd4 for a timeout, otherwise 0.

Function
REQ-023 The FSM SHALL have four states: IDLE, GNT_IF, GNT_D and ERR.
REQ-024 In IDLE with only one request pending, that requester SHALL be granted.
REQ-025 In IDLE with both requests pending, data SHALL win unless starve_cnt==STARVE_MAX, in which case fetch SHALL win.
REQ-026 starve_cnt (2+ bits) SHALL increment when fetch loses an arbitration, clear when fetch is granted, and saturate at STARVE_MAX.
REQ-027 On grant, the request SHALL be captured into registers and m_req/m_we/m_addr/m_wdata SHALL drive from those registers starting the next cycle (grant latency 1 cycle).
REQ-028 Bus outputs SHALL stay stable until m_ack or timeout; fetch grants SHALL drive m_we=0 and m_wdata=0.
REQ-029 On m_ack in GNT_IF, m_rdata SHALL be registered into if_rdata and if_cplt SHALL pulse the next cycle; the FSM SHALL then return to IDLE.
REQ-030 On m_ack in GNT_D, the FSM SHALL register m_rdata into d_rdata (loads only; stores leave d_rdata unchanged), pulse d_cplt the next cycle, and return to IDLE.
REQ-031 m_req SHALL deassert in the cycle after m_ack.
REQ-032 A completed requester SHALL NOT be re-granted in the same cycle its cplt is high; arbitration resumes the following cycle.
REQ-033 A wait counter SHALL clear on grant and increment each cycle m_req is high without m_ack.
REQ-034 When the wait counter reaches TIMEOUT_CYC, the FSM SHALL enter ERR.
REQ-035 ERR SHALL last one cycle: m_req=0, owning rdata=0, owning cplt=1, bus_err=1, err_num=4; the FSM SHALL then return to IDLE.
REQ-036 m_ack with m_req low SHALL be ignored.
REQ-037 An m_ack arriving in the same cycle the count reaches TIMEOUT_CYC SHALL take priority: normal completion, no error.
REQ-038 Deassertion of a requester's req mid-transaction SHALL NOT abort the transfer; the transfer completes and cplt still pulses.
REQ-039 if_cplt and d_cplt SHALL never be high in the same cycle.

Reset
REQ-040 rst low SHALL immediately force state=IDLE, m_req=0, m_we=0, m_addr=0, m_wdata=0, if_rdata=0, d_rdata=0, if_cplt=0, d_cplt=0, bus_err=0, err_num=0, starve_cnt=0 and wait counter=0, independent of clk.
REQ-041 Reset asserted mid-transaction SHALL drop m_req at once, and no cplt SHALL be issued for the aborted transfer.
REQ-042 After rst rises, the first arbitration SHALL occur on the first rising edge at which a req is high.

Verification
REQ-043 if_req=1, if_addr=0x100, m_ack 3 cycles after m_req with m_rdata=0xDEADBEEF -> m_addr=0x100, m_we=0, if_rdata=0xDEADBEEF, one if_cplt pulse.
REQ-044 if_req and d_req both held, d_we=1, d_addr=0x2000, d_wdata=0x55, immediate acks -> data granted 3 times, then fetch on the 4th arbitration, starve_cnt back to 0.
REQ-045 d_req=1 load, m_ack never asserted, TIMEOUT_CYC=8 -> ERR 8 cycles after m_req rises, bus_err=1, err_num=4, d_cplt=1, d_rdata=0.
REQ-046 rst pulled low while m_req=1 in GNT_D -> m_req=0 asynchronously, no d_cplt, and a fresh grant after release.
REQ-047 m_ack in the exact timeout cycle -> normal completion, bus_err stays 0.
REQ-048 Spurious m_ack in IDLE -> no cplt and no state change.
